// File: rtl/argmax_stream_ctrl_if.sv
// Score-in / prediction-out handshake bundle for argmax_stream_ctrl; ARGMAX_SCORE_OUT_EN adds max_score.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready for scores, out_valid/out_ready for the prediction.
interface argmax_stream_ctrl_if #(
    parameter int DATA_WIDTH = 29,
    parameter int IDX_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_WIDTH-1:0]  predict;
    logic                  frame_err;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [DATA_WIDTH-1:0] max_score;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, predict, frame_err, max_score
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, predict, frame_err, max_score
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, predict, frame_err
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, predict, frame_err
    );
`endif
endinterface

// File: rtl/argmax_stream_ctrl.sv
// Serial argmax over a frame of signed scores; ARGMAX_SCORE_OUT_EN also exports the winning score.
// Latency: out_valid rises one cycle after the frame-ending beat is accepted.
// Backpressure: in_ready is low while a result is held; the result waits for out_ready, giving a 1-cycle bubble.
module argmax_stream_ctrl #(
    parameter int DATA_WIDTH  = 29,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    argmax_stream_ctrl_if.slave   bus
);
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    logic [0:0]                   state_q, state_d;
    logic [IDX_WIDTH-1:0]         count_q, count_d;
    logic [IDX_WIDTH-1:0]         max_idx_q, max_idx_d;
    logic [IDX_WIDTH-1:0]         predict_q, predict_d;
    logic signed [DATA_WIDTH-1:0] max_reg_q, max_reg_d;
    logic                         frame_err_q, frame_err_d;
    logic                         beat_acc;
    logic                         at_last_idx;

    // Next-state: track running max during COLLECT, latch the result at frame end, wait for the sink in HOLD.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        max_idx_d   = max_idx_q;
        max_reg_d   = max_reg_q;
        predict_d   = predict_q;
        frame_err_d = frame_err_q;
        beat_acc    = bus.in_valid && (state_q == ST_COLLECT);
        at_last_idx = (count_q == LAST_IDX);

        if (beat_acc) begin
            // First beat loads unconditionally; later beats replace only when strictly greater,
            // so ties keep the lower index. count_q is the pre-update index of this beat.
            if ((count_q == '0) || ($signed(bus.in_data) > max_reg_q)) begin
                max_reg_d = $signed(bus.in_data);
                max_idx_d = count_q;
            end
            if (bus.in_last || at_last_idx) begin
                predict_d   = max_idx_d;
                frame_err_d = bus.in_last ^ at_last_idx;
                count_d     = '0;
                state_d     = ST_HOLD;
            end else begin
                count_d = count_q + IDX_WIDTH'(1);
            end
        end else if ((state_q == ST_HOLD) && bus.out_ready) begin
            state_d = ST_COLLECT;
        end
    end

    // State registers with synchronous reset; reset drops any partial frame or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            count_q     <= '0;
            max_idx_q   <= '0;
            max_reg_q   <= '0;
            predict_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            max_idx_q   <= max_idx_d;
            max_reg_q   <= max_reg_d;
            predict_q   <= predict_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Handshake outputs decode the state register only, so no path from in_valid or out_ready.
    assign bus.in_ready  = (state_q == ST_COLLECT);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.predict   = predict_q;
    assign bus.frame_err = frame_err_q;
`ifdef ARGMAX_SCORE_OUT_EN
    // max_reg is untouched while in HOLD, so it is stable for as long as out_valid is high.
    assign bus.max_score = max_reg_q;
`endif

endmodule
